// File: rtl/rr_grant_pkg.sv
// Shared definitions for the round-robin grant controller: FSM state encoding
// and the width of the hold/gap counter.
package rr_grant_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: returns the first requester found
// searching ptr+1, ptr+2, ... modulo N_REQ, plus a flag that anyone requested.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   ptr,
  output logic             any,
  output logic [IDW-1:0]   winner
);

  logic [IDW-1:0]   cand [N_REQ];
  logic [N_REQ-1:0] hit;

  // cand[gi] is the requester examined at search position gi (0 = highest priority)
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
    assign cand[gi] = IDW'((int'(ptr) + gi + 1) % N_REQ);
    assign hit[gi]  = req[cand[gi]];
  end

  always_comb begin
    any    = |req;
    winner = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (hit[k]) winner = cand[k];
    end
  end

endmodule

// File: rtl/rr_grant_ctrl.sv
// Round-robin arbiter/sequencer granting one requester at a time for HOLD
// cycles followed by a GAP-cycle recovery. Define RR_GRANT_PRIO0_EN to make
// requester 0 win every arbitration in which it requests.
module rr_grant_ctrl
  import rr_grant_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int HOLD  = 2,
  parameter int GAP   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic                     rel,
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] gnt_id,
  output logic                     gnt_vld,
  output logic                     busy
);

  localparam int IDW = $clog2(N_REQ);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP - 1);

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [IDW-1:0]     ptr_reg, ptr_next;
  logic [N_REQ-1:0]   gnt_reg, gnt_next;
  logic [IDW-1:0]     id_reg, id_next;

  logic               pick_any;
  logic [IDW-1:0]     pick_id;
  logic [IDW-1:0]     sel_id;
  logic [N_REQ-1:0]   sel_onehot;
  logic               arb;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_pick (
    .req    (req),
    .ptr    (ptr_reg),
    .any    (pick_any),
    .winner (pick_id)
  );

`ifdef RR_GRANT_PRIO0_EN
  assign sel_id = req[0] ? '0 : pick_id;
`else
  assign sel_id = pick_id;
`endif

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_onehot
    assign sel_onehot[gi] = (sel_id == IDW'(gi));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      ptr_reg   <= IDW'(N_REQ - 1);
      gnt_reg   <= '0;
      id_reg    <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      ptr_reg   <= ptr_next;
      gnt_reg   <= gnt_next;
      id_reg    <= id_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    ptr_next   = ptr_reg;
    gnt_next   = gnt_reg;
    id_next    = id_reg;
    arb        = 1'b0;

    case (state_reg)
      ST_IDLE: arb = 1'b1;
      ST_GRANT: begin
        cnt_next = cnt_reg + CNT_W'(1);
        if (cnt_reg == HOLD_LAST || rel) begin
          cnt_next = '0;
          gnt_next = '0;
          if (GAP != 0) state_next = ST_GAP;
          else          arb        = 1'b1;
        end
      end
      ST_GAP: begin
        cnt_next = cnt_reg + CNT_W'(1);
        if (cnt_reg == GAP_LAST) begin
          cnt_next = '0;
          arb      = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // Arbitration point: idle, end of gap, or end of grant when there is no gap
    if (arb) begin
      if (pick_any) begin
        state_next = ST_GRANT;
        cnt_next   = '0;
        gnt_next   = sel_onehot;
        id_next    = sel_id;
        ptr_next   = sel_id;
      end else begin
        state_next = ST_IDLE;
        gnt_next   = '0;
      end
    end
  end

  assign gnt     = gnt_reg;
  assign gnt_id  = id_reg;
  assign gnt_vld = |gnt_reg;
  assign busy    = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_rr_grant_ctrl.sv
// Bench for rr_grant_ctrl: three configurations share stimulus and are each
// compared every cycle with a behavioural grant/gap model.
module tb_rr_grant_ctrl;

  localparam int N = 4;
  localparam int NI = 3;
  localparam int HOLD_T [NI] = '{2, 1, 4};
  localparam int GAP_T  [NI] = '{1, 0, 2};

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       rel;

  logic [3:0] gnt_w  [NI];
  logic [1:0] id_w   [NI];
  logic       vld_w  [NI];
  logic       busy_w [NI];

  int n_chk  = 0;
  int n_fail = 0;

  // behavioural model state per instance
  int m_on   [NI];
  int m_id   [NI];
  int m_ptr  [NI];
  int m_used [NI];
  int m_gapl [NI];

  int   starts[$];
  logic prev_v;
  logic [3:0] prev_g;

  always #5 clk = ~clk;

  rr_grant_ctrl #(.N_REQ(4), .HOLD(2), .GAP(1)) u0 (
    .clk(clk), .rst(rst), .req(req), .rel(rel),
    .gnt(gnt_w[0]), .gnt_id(id_w[0]), .gnt_vld(vld_w[0]), .busy(busy_w[0]));

  rr_grant_ctrl #(.N_REQ(4), .HOLD(1), .GAP(0)) u1 (
    .clk(clk), .rst(rst), .req(req), .rel(rel),
    .gnt(gnt_w[1]), .gnt_id(id_w[1]), .gnt_vld(vld_w[1]), .busy(busy_w[1]));

  rr_grant_ctrl #(.N_REQ(4), .HOLD(4), .GAP(2)) u2 (
    .clk(clk), .rst(rst), .req(req), .rel(rel),
    .gnt(gnt_w[2]), .gnt_id(id_w[2]), .gnt_vld(vld_w[2]), .busy(busy_w[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input int ptr, input logic [3:0] r);
`ifdef RR_GRANT_PRIO0_EN
    if (r[0]) return 0;
`endif
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (ptr + k) % N;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_on[i] = 0; m_id[i] = 0; m_ptr[i] = N - 1; m_used[i] = 0; m_gapl[i] = 0;
    end
  endtask

  task automatic model_step(input int i);
    bit arb;
    int w;
    arb = 1'b0;
    if (m_on[i] != 0) begin
      m_used[i]++;
      if (m_used[i] == HOLD_T[i] || rel) begin
        m_on[i] = 0;
        if (GAP_T[i] > 0) m_gapl[i] = GAP_T[i];
        else arb = 1'b1;
      end
    end else if (m_gapl[i] > 0) begin
      m_gapl[i]--;
      if (m_gapl[i] == 0) arb = 1'b1;
    end else begin
      arb = 1'b1;
    end
    if (arb && req != 4'b0) begin
      w = pick(m_ptr[i], req);
      m_on[i] = 1; m_id[i] = w; m_ptr[i] = w; m_used[i] = 0;
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < NI; i++) begin
      logic [3:0] eg;
      eg = (m_on[i] != 0) ? 4'(1 << m_id[i]) : 4'b0;
      chk($sformatf("u%0d_gnt", i), 32'(gnt_w[i]), 32'(eg));
      chk($sformatf("u%0d_gnt_id", i), 32'(id_w[i]), 32'(m_id[i]));
      chk($sformatf("u%0d_gnt_vld", i), 32'(vld_w[i]), 32'(m_on[i] != 0));
      chk($sformatf("u%0d_busy", i), 32'(busy_w[i]), 32'((m_on[i] != 0) || (m_gapl[i] > 0)));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) for (int i = 0; i < NI; i++) model_step(i);
    #1;
    check_all();
  endtask

  task automatic async_reset();
    rst = 1'b0;
    model_reset();
    #1;
    check_all();
  endtask

  initial begin
    int exp_fair [5];
    rst = 1'b0;
    req = 4'b1111;
    rel = 1'b0;
    model_reset();

    // reset held with all requests active
    for (int c = 0; c < 3; c++) tick();
    chk("rst_gnt", 32'(gnt_w[0]), 32'h0);
    chk("rst_busy", 32'(busy_w[0]), 32'h0);
    chk("rst_vld", 32'(vld_w[0]), 32'h0);

    // release: requester 0 first, then fairness over 14 cycles
    rst = 1'b1;
    prev_v = 1'b0;
    for (int c = 0; c < 14; c++) begin
      tick();
      if (c == 0) begin
        chk("first_gnt", 32'(gnt_w[0]), 32'h1);
        chk("first_id", 32'(id_w[0]), 32'h0);
      end
      if (vld_w[0] && !prev_v) starts.push_back(int'(id_w[0]));
      prev_v = vld_w[0];
    end
`ifdef RR_GRANT_PRIO0_EN
    exp_fair = '{0, 0, 0, 0, 0};
`else
    exp_fair = '{0, 1, 2, 3, 0};
`endif
    chk("fair_count", 32'(starts.size() >= 5), 32'h1);
    for (int k = 0; k < 5 && k < starts.size(); k++)
      chk($sformatf("fair_seq%0d", k), 32'(starts[k]), 32'(exp_fair[k]));

    // reset in the 2nd cycle of a grant to requester 2
    async_reset();
    req = 4'b0100;
    tick();
    rst = 1'b1;
    tick();
    chk("mid_first", 32'(gnt_w[0]), 32'h4);
    tick();
    async_reset();
    chk("mid_drop", 32'(gnt_w[0]), 32'h0);
    tick();
    rst = 1'b1;
    tick();
    chk("mid_regrant", 32'(id_w[0]), 32'h2);
    req = 4'b1111;
    tick();
    tick();
    tick();

    // early release on the first grant cycle of the HOLD=4 instance
    req = 4'b0000;
    for (int c = 0; c < 8; c++) tick();
    req = 4'b0100;
    tick();
    chk("erel_on", 32'(gnt_w[2]), 32'h4);
    rel = 1'b1;
    req = 4'b0000;
    tick();
    chk("erel_gnt", 32'(gnt_w[2]), 32'h0);
    chk("erel_busy", 32'(busy_w[2]), 32'h1);
    rel = 1'b0;

    // back-to-back one-cycle grants with no gap
    for (int c = 0; c < 8; c++) tick();
    req = 4'b1010;
    for (int c = 0; c < 8; c++) begin
      tick();
      chk("b2b_vld", 32'(vld_w[1]), 32'h1);
      if (c > 0)
        chk("b2b_alt", 32'((gnt_w[1] == 4'b0010 && prev_g == 4'b1000) ||
                           (gnt_w[1] == 4'b1000 && prev_g == 4'b0010)), 32'h1);
      prev_g = gnt_w[1];
    end

    // randomized traffic with early releases and occasional resets
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 2) == 0) req = 4'($urandom_range(0, 15));
      rel = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 99) == 0) begin
        async_reset();
        tick();
        rst = 1'b1;
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
